present_manager: RTL
====================

PRESENT_MANAGER -- requirements
Module: present_manager

Interface
REQ-001 Parameters SHALL be: FALL_SPEED=2 (pixels/frame); FLOOR_Y=447 (resting top Y); REST_FRAMES=180 (frames on floor before vanishing); X_MAX=607 (rightmost spawn X); LFSR_SEED=16'hACE1.
REQ-002 clk  in  1  system clock; single clock domain.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 startOfFrame  in  1  one-cycle frame tick; paces motion and rest timing.
REQ-005 gameState  in  2  0=welcome, 1=play, 2=gameOver.
REQ-006 presentDrop  in  1  one-cycle spawn request from the game controller.
REQ-007 col_present  in  1  one-cycle player/present collision pulse.
REQ-008 presentType  out  2  00=life, 01=super rope, 10=super speed, 11=immortal; registered.
REQ-009 presentX  out  11  present top-left X; registered.
REQ-010 presentY  out  11  present top-left Y; registered.
REQ-011 presentActive  out  1  high while a present exists (FALLING or RESTING).

Function
REQ-012 State machine SHALL have states IDLE, FALLING, RESTING; at most one present exists at a time.
REQ-013 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clock, never reach zero, and load LFSR_SEED on reset.
REQ-014 IDLE->FALLING SHALL occur on the cycle after presentDrop=1 while gameState==1; presentDrop in any other state is ignored (not queued).
REQ-015 On spawn: presentType<=lfsr[1:0]; presentY<=0; presentX<=lfsr[9:0] if <=X_MAX, otherwise lfsr[9:0]-512.
REQ-016 FALLING, on startOfFrame: if presentY+FALL_SPEED>=FLOOR_Y then presentY<=FLOOR_Y, rest counter<=REST_FRAMES, go RESTING; otherwise presentY<=presentY+FALL_SPEED. Compute the sum at 12 bits; no wrap.
REQ-017 RESTING, on startOfFrame: decrement rest counter; when the counter is 0 at a tick, go IDLE.
REQ-018 col_present=1 in FALLING or RESTING SHALL force IDLE on the next cycle; col_present in IDLE is ignored.
REQ-019 presentType SHALL hold its value from spawn until the next spawn, including the collision cycle and IDLE, so the consumer samples it alongside col_present.
REQ-020 presentX/presentY SHALL freeze while IDLE.
REQ-021 presentActive SHALL be 1 exactly when state is FALLING or RESTING.
REQ-022 gameState!=1 SHALL force IDLE on the next cycle from any state.
REQ-023 Simultaneous-event priority: gameState!=1 > col_present > startOfFrame motion/timer > presentDrop.
REQ-024 Motion and timer SHALL change only on startOfFrame cycles; presentY never exceeds FLOOR_Y.

Reset
REQ-025 reset=1 SHALL set state IDLE, presentActive=0, presentX=0, presentY=0, presentType=00, rest counter=0, LFSR=LFSR_SEED, with the values visible on the next clock edge.
REQ-026 reset asserted mid-fall or mid-rest SHALL abort the present, with no collision or despawn side effect.

Structure
REQ-027 Package present_pkg SHALL hold the state enum, type encodings, FALL_SPEED, FLOOR_Y, REST_FRAMES, X_MAX, LFSR_SEED and the tap mask.
REQ-028 The LFSR SHALL be a sub-module lfsr16 (clk, reset, seed, q[15:0]); the FSM, position and rest counter stay in present_manager.

Verification
REQ-029 reset, gameState=1, presentDrop pulse with lfsr=16'h0265 -> next cycle presentActive=1, presentX=613-512=101, presentY=0, presentType=01.
REQ-030 Spawn, then 223 startOfFrame ticks -> presentY=446; next tick -> presentY=447, state RESTING; after 181 further ticks -> presentActive=0.
REQ-031 FALLING with presentY=100, col_present and startOfFrame in the same cycle -> IDLE, presentY stays 100, presentType unchanged.
REQ-032 presentDrop pulses while FALLING and while RESTING -> no respawn, presentX/presentType unchanged.
REQ-033 RESTING, gameState goes to 2 -> presentActive=0 next cycle; presentDrop while gameState=2 -> no spawn.
REQ-034 reset pulse mid-fall (presentY=300) -> all outputs at reset values next cycle; LFSR restarts at 16'hACE1.

Source files
------------

// File: rtl/present_pkg.sv
// Shared types and constants for the falling-present block: FSM states, game-state
// and present-type encodings, motion/timing constants and the LFSR definition.
package present_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FALLING = 2'd1,
    RESTING = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GS_WELCOME   = 2'd0,
    GS_PLAY      = 2'd1,
    GS_GAME_OVER = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    PT_LIFE        = 2'b00,
    PT_SUPER_ROPE  = 2'b01,
    PT_SUPER_SPEED = 2'b10,
    PT_IMMORTAL    = 2'b11
  } present_type_t;

  localparam int FALL_SPEED  = 2;
  localparam int FLOOR_Y     = 447;
  localparam int REST_FRAMES = 180;
  localparam int X_MAX       = 607;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Spawn column: raw 10-bit value, folded back by 512 when it would overrun X_MAX.
  function automatic logic [10:0] spawn_x(input logic [9:0] raw);
    if (raw > 10'(X_MAX))
      return 11'(raw) - 11'd512;
    else
      return 11'(raw);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free-running every clock; synchronous load of the seed.
module lfsr16
  import present_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // NOTE: sequential state uses non-blocking (<=) so all registers update from
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset || q == 16'h0000)
      q <= seed;
    else
      q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/present_manager.sv
// Single falling present: spawns at a pseudo-random X, falls one step per frame,
// rests on the floor for a fixed number of frames, then vanishes.
module present_manager
  import present_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [1:0]  gameState,
  input  logic        presentDrop,
  input  logic        col_present,
  output logic [1:0]  presentType,
  output logic [10:0] presentX,
  output logic [10:0] presentY,
  output logic        presentActive
);

  state_t      state, state_next;
  logic [15:0] lfsr_q;
  logic [7:0]  rest_cnt;
  logic [11:0] y_sum;
  logic        playing;
  logic        landing;
  logic        unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign unused_lfsr_bits = ^lfsr_q[15:10];
  assign playing = (gameState == GS_PLAY);
  // Sum carried at 12 bits so the floor compare can never see a wrapped value.
  assign y_sum   = {1'b0, presentY} + 12'(FALL_SPEED);
  assign landing = (y_sum >= 12'(FLOOR_Y));

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // NOTE: state_next is defaulted before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    state_next = state;
    if (!playing) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:
          if (presentDrop) state_next = FALLING;
        FALLING:
          if (col_present)                  state_next = IDLE;
          else if (startOfFrame && landing) state_next = RESTING;
        RESTING:
          if (col_present)                             state_next = IDLE;
          else if (startOfFrame && rest_cnt == 8'd0)   state_next = IDLE;
        default:
          state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    presentActive = (state == FALLING) || (state == RESTING);
  end

  // Position, type and rest timer; everything freezes outside play and on collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      presentType <= 2'b00;
      presentX    <= 11'd0;
      presentY    <= 11'd0;
      rest_cnt    <= 8'd0;
    end else if (playing && !(col_present && state != IDLE)) begin
      case (state)
        IDLE:
          if (presentDrop) begin
            presentType <= lfsr_q[1:0];
            presentX    <= spawn_x(lfsr_q[9:0]);
            presentY    <= 11'd0;
          end
        FALLING:
          if (startOfFrame) begin
            if (landing) begin
              presentY <= 11'(FLOOR_Y);
              rest_cnt <= 8'(REST_FRAMES);
            end else begin
              presentY <= y_sum[10:0];
            end
          end
        RESTING:
          if (startOfFrame && rest_cnt != 8'd0)
            rest_cnt <= rest_cnt - 8'd1;
        default: ;
      endcase
    end
  end

endmodule
